// File: rtl/run_controller_if.sv
// run_controller_if: program-load valid/ready stream from host to controller
interface run_controller_if #(parameter int XLEN = 32);
  logic load_valid;
  logic [XLEN-1:0] load_data;
  logic load_last;
  logic load_ready;
  modport master(output load_valid, load_data, load_last, input load_ready);
  modport slave(input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/run_controller.sv
// run_controller: loads instruction memory, then gates datapath retirement (run/step/halt/watchdog)
module run_controller #(
  parameter int XLEN = 32,
  parameter int IMEM_DEPTH = 128,
  parameter int AW = $clog2(IMEM_DEPTH),
  parameter int CYCLE_W = 32,
  parameter int MAX_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  run_controller_if.slave load,
  input  logic start,
  input  logic step,
  input  logic halt_req,
  input  logic clear,
  input  logic [XLEN-1:0] instr,
  output logic imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [XLEN-1:0] imem_wdata,
  output logic core_rst,
  output logic pc_en,
  output logic [2:0] state,
  output logic halted,
  output logic error,
  output logic [CYCLE_W-1:0] cycle_count
);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, STEP = 3'd3, HALT = 3'd4} state_t;
  state_t st, st_n;
  logic loaded, loaded_n, error_n, beat, at_end, halt_instr, wd;
  logic [AW-1:0] ptr, ptr_n;
  logic [CYCLE_W-1:0] cnt_n;
  assign load.load_ready = st == IDLE || st == LOAD;
  assign core_rst = load.load_ready;
  assign state = st;
  assign halted = st == HALT;
  assign beat = load.load_valid && load.load_ready;
  assign at_end = ptr == AW'(IMEM_DEPTH - 1);
  assign halt_instr = instr == XLEN'(32'h00000073) || instr == XLEN'(32'h00100073);
  assign pc_en = (st == RUN || st == STEP) && !halt_instr;
  assign cnt_n = pc_en && !(&cycle_count) ? cycle_count + 1'b1 : cycle_count;
  // watchdog fires on the retiring cycle that brings the count to the limit
  assign wd = MAX_CYCLES != 0 && pc_en && cnt_n == CYCLE_W'(MAX_CYCLES);
  always_comb begin
    st_n = st;
    loaded_n = loaded;
    ptr_n = ptr;
    error_n = error;
    if (clear) begin
      st_n = IDLE;
      loaded_n = 1'b0;
      ptr_n = '0;
      error_n = 1'b0;
    end else if (beat) begin
      loaded_n = load.load_last;
      ptr_n = load.load_last || at_end ? '0 : ptr + 1'b1;
      st_n = load.load_last ? IDLE : at_end ? HALT : LOAD;
      error_n = error || (!load.load_last && at_end);
    end else begin
      case (st)
        IDLE: st_n = !loaded ? IDLE : start ? RUN : step ? STEP : IDLE;
        RUN: begin
          st_n = halt_instr || halt_req || wd ? HALT : RUN;
          error_n = error || wd;
        end
        STEP: st_n = HALT;
        HALT: st_n = error ? HALT : start ? RUN : step ? STEP : HALT;
        default: st_n = st;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      loaded <= 1'b0;
      ptr <= '0;
      error <= 1'b0;
      cycle_count <= '0;
      imem_we <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      st <= st_n;
      loaded <= loaded_n;
      ptr <= ptr_n;
      error <= error_n;
      cycle_count <= clear ? '0 : cnt_n;
      imem_we <= beat && !clear;
      if (beat && !clear) begin
        imem_waddr <= ptr;
        imem_wdata <= load.load_data;
      end
    end
  end
endmodule
